// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Holds the requester index, the writeback request bundle and the starvation counter width.
package rf_wb_arbiter_pkg;

    localparam int unsigned RD_W         = 5;
    localparam int unsigned STARVE_CNT_W = 4;
    // Width of the data field in the request bundle; must be >= DATA_WIDTH of the arbiter.
    localparam int unsigned WB_DATA_W    = 32;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_idx_t;

    typedef struct packed {
        logic                 valid;
        logic [RD_W-1:0]      rd;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_prio_sel.sv
// Two-way combinational grant selector: a lone valid wins, contention goes to i_pref.
// Output is one-hot (bit N = grant to requester N) or zero when nothing is valid.
module wb_prio_sel
    import rf_wb_arbiter_pkg::*;
(
    input  logic [1:0] i_valid,
    input  req_idx_t   i_pref,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        unique case (i_valid)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = (i_pref == REQ1) ? 2'b10 : 2'b01;
            default: o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates two writeback sources onto one register-file write port, one cycle of latency.
// Config macro RF_WB_ARB_RR_EN: defined = round-robin, undefined = fixed priority with req1 anti-starvation.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  req0_valid,
    input  logic [4:0]            req0_rd,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [4:0]            req1_rd,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  wr_en,
    output logic [4:0]            wr_rd,
    output logic [DATA_WIDTH-1:0] wr_data
);

    wb_req_t               w_req0;
    wb_req_t               w_req1;
    wb_req_t               w_win;
    req_idx_t              w_pref;
    logic [1:0]            w_grant;
    logic                  w_xfer;

    logic                  r_wr_en;
    logic [RD_W-1:0]       r_wr_rd;
    logic [DATA_WIDTH-1:0] r_wr_data;

    always_comb begin
        w_req0.valid = req0_valid;
        w_req0.rd    = req0_rd;
        w_req0.data  = WB_DATA_W'(req0_data);
        w_req1.valid = req1_valid;
        w_req1.rd    = req1_rd;
        w_req1.data  = WB_DATA_W'(req1_data);
    end

`ifdef RF_WB_ARB_RR_EN
    req_idx_t r_last_grant;

    // Reset value REQ1 makes req0 the winner of the first contention.
    always_ff @(posedge clk or posedge arst) begin
        if (arst)
            r_last_grant <= REQ1;
        else if (w_xfer)
            r_last_grant <= w_grant[1] ? REQ1 : REQ0;
    end

    always_comb begin
        w_pref = (r_last_grant == REQ0) ? REQ1 : REQ0;
    end
`else
    logic [STARVE_CNT_W-1:0] r_starve_cnt;

    // Counts consecutive denied cycles of a waiting req1; at the limit req1 takes priority.
    always_ff @(posedge clk or posedge arst) begin
        if (arst)
            r_starve_cnt <= '0;
        else if (!req1_valid || w_grant[1])
            r_starve_cnt <= '0;
        else
            r_starve_cnt <= r_starve_cnt + 1'b1;
    end

    always_comb begin
        w_pref = (r_starve_cnt == STARVE_CNT_W'(STARVE_LIMIT)) ? REQ1 : REQ0;
    end
`endif

    wb_prio_sel u_sel (
        .i_valid ({w_req1.valid, w_req0.valid}),
        .i_pref  (w_pref),
        .o_grant (w_grant)
    );

    always_comb begin
        w_xfer = |w_grant;
        w_win  = w_grant[1] ? w_req1 : w_req0;
    end

    // Writes to x0 are consumed but leave the output address/data untouched.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_wr_en   <= 1'b0;
            r_wr_rd   <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_xfer && (w_win.rd != '0);
            if (w_xfer && (w_win.rd != '0)) begin
                r_wr_rd   <= w_win.rd;
                r_wr_data <= DATA_WIDTH'(w_win.data);
            end
        end
    end

    always_comb begin
        req0_ready = w_grant[0];
        req1_ready = w_grant[1];
        wr_en      = r_wr_en;
        wr_rd      = r_wr_rd;
        wr_data    = r_wr_data;
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter; covers both RF_WB_ARB_RR_EN builds.
module tb_rf_wb_arbiter;

    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          arst;
    logic          req0_valid, req1_valid;
    logic [4:0]    req0_rd, req1_rd;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          wr_en;
    logic [4:0]    wr_rd;
    logic [DW-1:0] wr_data;

    int unsigned total = 0;
    int unsigned bad   = 0;

`ifdef RF_WB_ARB_RR_EN
    localparam logic [11:0] EXP_A = 12'hAAA;
    localparam logic [11:0] EXP_B = 12'hAAA;
`else
    localparam logic [11:0] EXP_A = 12'h210;
    localparam logic [11:0] EXP_B = 12'h210;
`endif

    rf_wb_arbiter #(.DATA_WIDTH(DW), .STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .arst       (arst),
        .req0_valid (req0_valid),
        .req0_rd    (req0_rd),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_rd    (req1_rd),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .wr_en      (wr_en),
        .wr_rd      (wr_rd),
        .wr_data    (wr_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Both requesters held valid for n cycles; bit i of exp_g1 says req1 wins cycle i.
    task automatic contend(input string tag, input logic [11:0] exp_g1, input int n);
        logic g1;
        req0_valid = 1'b1; req0_rd = 5'd1; req0_data = 32'h100;
        req1_valid = 1'b1; req1_rd = 5'd2; req1_data = 32'h200;
        for (int i = 0; i < n; i++) begin
            g1 = exp_g1[i];
            #1;
            chk({tag, "_rdy1"}, 64'(req1_ready), 64'(g1));
            chk({tag, "_rdy0"}, 64'(req0_ready), 64'(!g1));
            step();
            chk({tag, "_wren"}, 64'(wr_en), 64'd1);
            chk({tag, "_wrrd"}, 64'(wr_rd), g1 ? 64'd2 : 64'd1);
            chk({tag, "_wrdata"}, 64'(wr_data), g1 ? 64'h200 : 64'h100);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        arst = 1'b1;
        req0_valid = 1'b0; req0_rd = '0; req0_data = '0;
        req1_valid = 1'b0; req1_rd = '0; req1_data = '0;
        #2;
        chk("rst_wren", 64'(wr_en), 64'd0);
        chk("rst_wrrd", 64'(wr_rd), 64'd0);
        chk("rst_wrdata", 64'(wr_data), 64'd0);
        chk("rst_rdy0", 64'(req0_ready), 64'd0);
        chk("rst_rdy1", 64'(req1_ready), 64'd0);
        @(negedge clk);
        arst = 1'b0;
        step();

        // Lone req0 write
        req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'hDEADBEEF;
        #1;
        chk("t1_rdy0", 64'(req0_ready), 64'd1);
        chk("t1_rdy1", 64'(req1_ready), 64'd0);
        chk("t1_wren_pre", 64'(wr_en), 64'd0);
        step();
        chk("t1_wren", 64'(wr_en), 64'd1);
        chk("t1_wrrd", 64'(wr_rd), 64'd5);
        chk("t1_wrdata", 64'(wr_data), 64'hDEADBEEF);
        req0_valid = 1'b0;
        #1;
        chk("idle_rdy0", 64'(req0_ready), 64'd0);
        step();
        chk("idle_wren", 64'(wr_en), 64'd0);
        chk("idle_wrrd", 64'(wr_rd), 64'd5);

        // req1 write to x0 is consumed without a register-file write
        req1_valid = 1'b1; req1_rd = 5'd0; req1_data = 32'h1234;
        #1;
        chk("x0_rdy1", 64'(req1_ready), 64'd1);
        chk("x0_rdy0", 64'(req0_ready), 64'd0);
        step();
        chk("x0_wren", 64'(wr_en), 64'd0);
        chk("x0_wrrd", 64'(wr_rd), 64'd5);
        chk("x0_wrdata", 64'(wr_data), 64'hDEADBEEF);

        // Lone req1 write
        req1_rd = 5'd9; req1_data = 32'h55;
        #1;
        chk("t3_rdy1", 64'(req1_ready), 64'd1);
        step();
        chk("t3_wren", 64'(wr_en), 64'd1);
        chk("t3_wrrd", 64'(wr_rd), 64'd9);
        chk("t3_wrdata", 64'(wr_data), 64'h55);
        req1_valid = 1'b0;
        step();

        // Same destination from both sides: writes land in grant order
        req0_valid = 1'b1; req0_rd = 5'd7; req0_data = 32'hA;
        req1_valid = 1'b1; req1_rd = 5'd7; req1_data = 32'hB;
        #1;
        chk("same_rdy0", 64'(req0_ready), 64'd1);
        chk("same_rdy1", 64'(req1_ready), 64'd0);
        step();
        req0_valid = 1'b0;
        chk("same_wr1_en", 64'(wr_en), 64'd1);
        chk("same_wr1_rd", 64'(wr_rd), 64'd7);
        chk("same_wr1_data", 64'(wr_data), 64'hA);
        #1;
        chk("same_rdy1b", 64'(req1_ready), 64'd1);
        step();
        req1_valid = 1'b0;
        chk("same_wr2_en", 64'(wr_en), 64'd1);
        chk("same_wr2_rd", 64'(wr_rd), 64'd7);
        chk("same_wr2_data", 64'(wr_data), 64'hB);
        step();
        chk("same_idle_wren", 64'(wr_en), 64'd0);

        contend("cont", EXP_A, 12);
        step();

        // Build up arbiter state, then reset with a write pending
        req0_valid = 1'b1; req0_rd = 5'd3; req0_data = 32'h77;
        req1_valid = 1'b1; req1_rd = 5'd4; req1_data = 32'h88;
        for (int k = 0; k < 3; k++) step();
        chk("pre_rst_wrrd", 64'(wr_rd), 64'd3);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        arst = 1'b1;
        #1;
        chk("arst_wren", 64'(wr_en), 64'd0);
        chk("arst_wrrd", 64'(wr_rd), 64'd0);
        chk("arst_wrdata", 64'(wr_data), 64'd0);
        step();
        chk("arst_hold_wren", 64'(wr_en), 64'd0);
        @(negedge clk);
        arst = 1'b0;
        step();
        chk("post_rst_wren", 64'(wr_en), 64'd0);

        // Arbiter state must restart from its reset values
        contend("postrst", EXP_B, 10);
        step();
        chk("end_wren", 64'(wr_en), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
